// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous font ROM between the text pixel
// path (client 0) and a background client (client 1). Grants are
// combinational. Each granted word comes back on rdata two cycles after the
// grant, tagged with valid0 or valid1.
module font_rom_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              video_on,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              valid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              valid1,
  output logic [DATA_W-1:0] rdata,
  output logic              starve,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [7:0] LIMIT = STARVE_LIMIT[7:0];

  // last_q = 1 means client 1 was granted most recently, so client 0 wins the next tie
  logic              last_q, last_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  // Return tags: bit 0 is the grant cycle's read, bit 1 is one cycle older
  logic [1:0]        tag_v_q, tag_v_d;
  logic [1:0]        tag_id_q, tag_id_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              starve_q, starve_d;

  // Arbitration: strict priority during active video, otherwise round-robin; no grants in reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      if (video_on) begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
      end else if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // ROM address: the granted address, or the most recently granted address when idle
  always_comb begin
    if (gnt0)      rom_addr = addr0;
    else if (gnt1) rom_addr = addr1;
    else           rom_addr = hold_addr_q;
  end

  // Next-state logic for the arbiter, return pipeline and starvation counter
  always_comb begin
    last_d      = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_q);
    hold_addr_d = rom_addr;
    tag_v_d     = {tag_v_q[0], gnt0 | gnt1};
    tag_id_d    = {tag_id_q[0], gnt1};
    // ROM output is valid the cycle after its address was presented
    rdata_d     = tag_v_q[0] ? rom_data : rdata_q;
    if (req1 && !gnt1) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
    starve_d = (cnt_d >= LIMIT);
  end

  // State registers; reset discards any read in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q      <= 1'b1;
      hold_addr_q <= '0;
      tag_v_q     <= 2'b00;
      tag_id_q    <= 2'b00;
      rdata_q     <= '0;
      cnt_q       <= 8'd0;
      starve_q    <= 1'b0;
    end else begin
      last_q      <= last_d;
      hold_addr_q <= hold_addr_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
    end
  end

  assign valid0 = tag_v_q[1] & ~tag_id_q[1];
  assign valid1 = tag_v_q[1] &  tag_id_q[1];
  assign rdata  = rdata_q;
  assign starve = starve_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Testbench for font_rom_arbiter: directed scenarios followed by random
// traffic. Every output is compared each cycle against a reference model that
// schedules each expected return by cycle number.
module tb_font_rom_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int LIMIT  = 64;
  localparam int MAXC   = 4000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              video_on;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              gnt0, gnt1, valid0, valid1, starve;
  logic [DATA_W-1:0] rdata, rom_data;
  logic [ADDR_W-1:0] rom_addr;

  font_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n), .video_on(video_on),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .valid0(valid0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .valid1(valid1),
    .rdata(rdata), .starve(starve), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // Font ROM: one cycle of read latency
  logic [DATA_W-1:0] rom_mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Reference model: scheduled returns indexed by cycle number
  int                cyc;
  int                n_vec, n_err;
  logic              exp_v   [0:MAXC-1];
  logic              exp_id  [0:MAXC-1];
  logic [DATA_W-1:0] exp_data[0:MAXC-1];
  logic [ADDR_W-1:0] exp_addr[0:MAXC-1];
  int                m_last;
  logic [ADDR_W-1:0] m_hold;
  logic [DATA_W-1:0] m_rdata;
  int                m_run;
  logic              last_g0, last_g1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = cyc; i < MAXC; i++) exp_v[i] = 1'b0;
    m_last  = 1;
    m_hold  = '0;
    m_rdata = '0;
    m_run   = 0;
  endtask

  // One clock cycle: check all outputs mid-cycle, advance the model, cross the edge
  task automatic step();
    logic              e0, e1, v0, v1;
    logic [ADDR_W-1:0] ea;
    @(negedge clk);
    if (!reset_n) clear_model();
    e0 = 1'b0;
    e1 = 1'b0;
    if (reset_n) begin
      if (req0 && req1) begin
        if (video_on)         e0 = 1'b1;
        else if (m_last == 0) e1 = 1'b1;
        else                  e0 = 1'b1;
      end else begin
        e0 = req0;
        e1 = req1;
      end
    end
    ea = e0 ? addr0 : (e1 ? addr1 : m_hold);
    v0 = exp_v[cyc] && !exp_id[cyc];
    v1 = exp_v[cyc] &&  exp_id[cyc];
    if (exp_v[cyc]) begin
      m_rdata = exp_data[cyc];
      $display("read cyc=%0d client=%0d addr=%03h data=%02h", cyc, exp_id[cyc], exp_addr[cyc], exp_data[cyc]);
    end
    chk("gnt0", gnt0, e0);
    chk("gnt1", gnt1, e1);
    chk("rom_addr", rom_addr, ea);
    chk("valid0", valid0, v0);
    chk("valid1", valid1, v1);
    chk("rdata", rdata, m_rdata);
    chk("starve", starve, m_run >= LIMIT);
    if ((e0 || e1) && cyc + 2 < MAXC) begin
      exp_v[cyc+2]    = 1'b1;
      exp_id[cyc+2]   = e1;
      exp_addr[cyc+2] = ea;
      exp_data[cyc+2] = rom_mem[ea];
    end
    if (e0 || e1) begin
      m_last = e1 ? 1 : 0;
      m_hold = ea;
    end
    if (reset_n) m_run = (req1 && !e1) ? ((m_run < 255) ? m_run + 1 : 255) : 0;
    last_g0 = e0;
    last_g1 = e1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = DATA_W'($urandom);
    rom_mem[11'h415] = 8'hAB;
    rom_mem[11'h123] = 8'h5C;
    for (int i = 0; i < MAXC; i++) exp_v[i] = 1'b0;
    reset_n  = 1'b0;
    video_on = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    clear_model();
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Single read from client 0
    req0 = 1'b1; addr0 = 11'h415;
    step();
    req0 = 1'b0;
    repeat (4) step();

    // Round-robin with both clients requesting continuously, starting from reset
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 11'h010; addr1 = 11'h020;
    for (int i = 0; i < 4; i++) begin
      step();
      if (last_g0) addr0 = addr0 + 11'd1;
      if (last_g1) addr1 = addr1 + 11'd1;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    // Priority during active video; client 1 starves, then is served
    video_on = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr1 = 11'h2A7;
    for (int i = 0; i < 70; i++) begin
      addr0 = ADDR_W'($urandom);
      step();
    end
    req0 = 1'b0;
    step();
    req1 = 1'b0;
    repeat (3) step();

    // Idle hold after a client 1 read
    video_on = 1'b0;
    req1 = 1'b1; addr1 = 11'h123;
    step();
    req1 = 1'b0;
    repeat (5) step();

    // Reset while a read is in flight
    req0 = 1'b1; addr0 = 11'h415;
    step();
    req0 = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (3) step();
    req0 = 1'b1; req1 = 1'b1; addr0 = 11'h300; addr1 = 11'h301;
    step();
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    // Random traffic obeying the hold-until-granted handshake
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) video_on = ~video_on;
      if ($urandom_range(0, 199) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      if (last_g0 || !req0) begin
        req0  = ($urandom_range(0, 99) < 55);
        addr0 = ADDR_W'($urandom);
      end
      if (last_g1 || !req1) begin
        req1  = ($urandom_range(0, 99) < 55);
        addr1 = ADDR_W'($urandom);
      end
      step();
    end
    reset_n = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
